// File: rtl/dm_be_param_if.sv
// Bus bundle for the M-stage data memory: request, load data, status and write trace.
interface dm_be_param_if;
  logic [31:0] wpc;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] RD;
  logic        ready;
  logic        exc_align;
  logic        exc_range;
  logic        con;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;

  modport master (
    output wpc, WE, A, WD, size, sext,
    input  RD, ready, exc_align, exc_range, con, log_pc, log_addr, log_data
  );

  modport slave (
    input  wpc, WE, A, WD, size, sext,
    output RD, ready, exc_align, exc_range, con, log_pc, log_addr, log_data
  );
endinterface

// File: rtl/dm_be_param.sv
// Data memory with byte-enable stores, extending loads, exception flags and a
// post-reset clear sweep. Committed writes are exposed on a registered trace
// (con qualifies log_pc/log_addr/log_data) so the simulation log can be printed.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLEAR | zeroing dm[ptr] one word per cycle; accesses ignored, ready=0
// S_RUN   | normal load/store operation, ready=1
module dm_be_param #(
  parameter int DEPTH    = 3072,
  parameter int AW       = 12,
  parameter bit CLEAR_EN = 1'b1
) (
  input logic         clk,
  input logic         reset,
  dm_be_param_if.slave bus
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          con_q, con_d;
  logic [31:0]   log_pc_q, log_pc_d;
  logic [31:0]   log_addr_q, log_addr_d;
  logic [31:0]   log_data_q, log_data_d;

  logic [31:0]   dm [DEPTH];

  logic          run, in_range, mis, commit, clr_we;
  logic          is_half, is_byte;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wrep, word_rd, merged;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  // Address decode, exception detection and byte-lane merge of the store data
  always_comb begin
    run      = (state_q == S_RUN);
    idx      = bus.A[AW+1:2];
    lane     = bus.A[1:0];
    is_half  = (bus.size == 2'b01);
    is_byte  = (bus.size == 2'b10);
    in_range = ({2'b00, bus.A[31:2]} < 32'(DEPTH));
    mis      = is_half ? bus.A[0] : (!is_byte && (lane != 2'b00));
    // Guarded read: idx can exceed DEPTH-1 when the address is out of range
    word_rd  = in_range ? dm[idx] : '0;
    if (is_byte) begin
      be   = 4'b0001 << lane;
      wrep = {4{bus.WD[7:0]}};
    end else if (is_half) begin
      be   = lane[1] ? 4'b1100 : 4'b0011;
      wrep = {2{bus.WD[15:0]}};
    end else begin
      be   = 4'b1111;
      wrep = bus.WD;
    end
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word_rd[8*i +: 8];
    end
    commit = bus.WE && run && !mis && in_range;
    clr_we = !run && CLEAR_EN;
  end

  // State, pointer and write-trace registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      con_q      <= 1'b0;
      log_pc_q   <= '0;
      log_addr_q <= '0;
      log_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      con_q      <= con_d;
      log_pc_q   <= log_pc_d;
      log_addr_q <= log_addr_d;
      log_data_q <= log_data_d;
    end
  end

  // Next-state: sweep advances until the last word, then memory goes live
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    con_d      = commit;
    log_pc_d   = log_pc_q;
    log_addr_d = log_addr_q;
    log_data_d = log_data_q;
    if (commit) begin
      log_pc_d   = bus.wpc;
      log_addr_d = {bus.A[31:2], 2'b00};
      log_data_d = merged;
    end
    case (state_q)
      S_CLEAR: begin
        if (!CLEAR_EN || (ptr_q == AW'(DEPTH - 1))) state_d = S_RUN;
        else                                        ptr_d   = ptr_q + 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Memory array: sweep writes zeros, otherwise committed merged stores
  always_ff @(posedge clk) begin
    if (clr_we)      dm[ptr_q] <= '0;
    else if (commit) dm[idx]   <= merged;
  end

  // Outputs: extended load data and status, all forced quiet while clearing
  always_comb begin
    byte_sel      = word_rd[{lane, 3'b000} +: 8];
    half_sel      = lane[1] ? word_rd[31:16] : word_rd[15:0];
    bus.RD        = '0;
    if (run && !mis && in_range) begin
      if (is_byte)      bus.RD = {{24{bus.sext & byte_sel[7]}}, byte_sel};
      else if (is_half) bus.RD = {{16{bus.sext & half_sel[15]}}, half_sel};
      else              bus.RD = word_rd;
    end
    bus.ready     = run;
    bus.exc_align = run && mis;
    bus.exc_range = run && !in_range;
    bus.con       = con_q;
    bus.log_pc    = log_pc_q;
    bus.log_addr  = log_addr_q;
    bus.log_data  = log_data_q;
  end

endmodule

// File: tb/tb_dm_be_param.sv
// Directed bench: a 16-word instance for sweep timing and a 3072-word instance
// for the load/store table and range boundary; both share the request inputs.
module tb_dm_be_param;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dm_be_param_if ifb ();
  dm_be_param_if ifs ();

  dm_be_param #(.DEPTH(3072), .AW(12), .CLEAR_EN(1'b1)) u_big (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );
  dm_be_param #(.DEPTH(16), .AW(4), .CLEAR_EN(1'b1)) u_small (
    .clk(clk), .reset(reset), .bus(ifs.slave)
  );

  assign ifs.wpc  = ifb.wpc;
  assign ifs.WE   = ifb.WE;
  assign ifs.A    = ifb.A;
  assign ifs.WD   = ifb.WD;
  assign ifs.size = ifb.size;
  assign ifs.sext = ifb.sext;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write trace of the large instance
  always @(negedge clk) begin
    if (ifb.con === 1'b1)
      $display("%d@%h: *%h <= %h", $time, ifb.log_pc, ifb.log_addr, ifb.log_data);
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] rd;
    logic        al;
    logic        rg;
    logic        cn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic sx, input logic [31:0] rd,
                     input logic al, input logic rg, input logic cn);
    vec_t v;
    v.we = we; v.a = a; v.wd = wd; v.sz = sz; v.sx = sx;
    v.rd = rd; v.al = al; v.rg = rg; v.cn = cn;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sx);
    ifb.WE = we; ifb.A = a; ifb.WD = wd; ifb.size = sz; ifb.sext = sx;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    ifb.wpc  = 32'h0040_0000;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready_small", ifs.ready, 1'b0);
    check("rst_con_small", ifs.con, 1'b0);
    check("rst_ready_big", ifb.ready, 1'b0);

    // Release; requests during CLEAR must produce no flags and no data
    drive(1'b0, 32'h0000_3003, 32'h0, 2'b01, 1'b1);
    reset = 1'b1;
    #1;
    check("clear_align", ifs.exc_align, 1'b0);
    check("clear_range", ifb.exc_range, 1'b0);
    check("clear_rd", ifs.RD, 32'h0);
    n = 0;
    while (ifs.ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("small_sweep_len", 32'(n), 32'd16);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b0, 32'(i * 4), 32'h0, 2'b00, 1'b0);
      #1;
      check($sformatf("small_zero_w%0d", i), ifs.RD, 32'h0);
    end

    n = 0;
    while (ifb.ready !== 1'b1 && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    check("big_ready", ifb.ready, 1'b1);

    //   we    addr           wd             sz     sx    rd             al    rg    cn
    add(1'b1, 32'h0000_0010, 32'h1122_3344, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b0, 32'h1122_3344, 1'b0, 1'b0, 1'b0);
    add(1'b1, 32'h0000_0012, 32'hAAAA_5566, 2'b01, 1'b0, 32'h0000_1122, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b0, 32'h5566_3344, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0012, 32'h0,         2'b01, 1'b1, 32'h0000_5566, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0013, 32'h0,         2'b10, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
    add(1'b1, 32'h0000_0021, 32'h1234_5680, 2'b10, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0000_0021, 32'h0,         2'b10, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0021, 32'h0,         2'b10, 1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0020, 32'h0,         2'b00, 1'b0, 32'h0000_8000, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0020, 32'h0,         2'b01, 1'b1, 32'hFFFF_8000, 1'b0, 1'b0, 1'b0);
    add(1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0004, 32'h0,         2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0003, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0011, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0012, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 32'h0000_2FFC, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0000_2FFC, 32'h0,         2'b00, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    add(1'b1, 32'h1000_0010, 32'h0,         2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add(1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b0, 32'h5566_3344, 1'b0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_3000, 32'h0,         2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 32'h0000_2FFF, 32'hFFFF_FF7F, 2'b10, 1'b0, 32'h0000_00CA, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0000_2FFC, 32'h0,         2'b00, 1'b0, 32'h7FFE_F00D, 1'b0, 1'b0, 1'b0);
    add(1'b1, 32'h0000_2FFC, 32'h0102_0304, 2'b00, 1'b0, 32'h7FFE_F00D, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0000_2FFC, 32'h0,         2'b00, 1'b0, 32'h0102_0304, 1'b0, 1'b0, 1'b0);
    add(1'b1, 32'h0000_0020, 32'hFFFF_1234, 2'b01, 1'b1, 32'hFFFF_8000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 32'h0000_0020, 32'h0,         2'b00, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      ifb.wpc = 32'h0040_0000 + 32'(i * 4);
      drive(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].sz, vecs[i].sx);
      #1;
      check($sformatf("v%0d_rd", i), ifb.RD, vecs[i].rd);
      check($sformatf("v%0d_align", i), ifb.exc_align, vecs[i].al);
      check($sformatf("v%0d_range", i), ifb.exc_range, vecs[i].rg);
      @(posedge clk); #1;
      check($sformatf("v%0d_con", i), ifb.con, vecs[i].cn);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1;
    check("con_pulse_drop", ifb.con, 1'b0);

    // Reset mid-sweep, then a store attempt during the restarted sweep
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midsweep_ready", ifs.ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (5) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    drive(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0);
    @(posedge clk); #1; n++;
    check("clear_we_con", ifs.con, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    while (ifs.ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("restart_sweep_len", 32'(n), 32'd16);
    @(negedge clk);
    drive(1'b0, 32'h0000_0000, 32'h0, 2'b00, 1'b0);
    #1;
    check("restart_w0", ifs.RD, 32'h0);
    drive(1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0);
    #1;
    check("restart_w4", ifs.RD, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_be_param.md
Name: dm_be_param

Overview:
- Parametrised data memory for the M stage of the pipelined CPU.
- Adds the following behaviour:
  - sub-word stores (sw/sh/sb) with byte-enable merge;
  - sub-word loads (lw/lh/lhu/lb/lbu) with sign/zero extension;
  - alignment and range exception flags;
  - a sequential post-reset clear sweep, replacing the single-cycle bulk clear.
- Reads are combinational; writes commit on the rising edge of clk.
- Every committed write is logged for the grading trace.

Parameters:
- DEPTH, 3072, number of 32-bit words.
- AW, 12, word-index width; requires 2^AW >= DEPTH.
- CLEAR_EN, 1, 1 = run the clear sweep after reset, 0 = skip straight to RUN (contents undefined).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wpc  in  32  PC of the instruction in M; used for the write log only.
- WE  in  1  store request.
- A  in  32  byte address.
- WD  in  32  store data; the low byte/half is used for sb/sh.
- size  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- sext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- RD  out  32  load data, extended.
- ready  out  1  high when the memory accepts accesses.
- exc_align  out  1  misaligned access.
- exc_range  out  1  word index >= DEPTH.
- con  out  1  store committed this cycle (registered pulse).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, ptr=0, ready=0, con=0.
  - Memory contents are not touched asynchronously.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Each cycle: dm[ptr]<=0, then ptr<=ptr+1.
  - When ptr==DEPTH-1 the last word is written and state<=RUN.
  - ready rises on the first RUN cycle, so the sweep takes exactly DEPTH cycles after reset release.
  - WE is ignored in CLEAR; RD=0 and both exception flags are 0.
  - With CLEAR_EN=0, the state goes CLEAR->RUN on the first edge after release.
- Reset asserted mid-sweep: restart from ptr=0.
- RUN, index and byte-lane rules:
  - idx=A[AW+1:2]; lane=A[1:0].
  - exc_range=1 if A[31:2] >= DEPTH (upper bits included).
  - exc_align=1 if size=01 and A[0]=1, or size=00/11 and A[1:0]!=0.
  - Both flags are combinational, valid only when ready=1.
- RUN, store path:
  - A store commits only if WE & ready & !exc_align & !exc_range.
  - Byte enables:
    - word: 1111.
    - half: 0011 (lane 0) or 1100 (lane 2).
    - byte: 0001 shifted left by lane.
  - The replicated WD byte/half is merged into the enabled lanes only; other lanes keep their old value.
  - On commit: con<=1 for one cycle, and log "%d@%h: *%h <= %h" with $time, wpc, {A[31:2],2'b00}, and the full merged word.
  - No commit means no log and con<=0.
- RUN, load path:
  - RD selects the addressed byte/half from dm[idx] and extends it per sext.
  - Word loads return dm[idx] unchanged.
  - On any exception, RD=0.
- Store and load to the same word in the same cycle: RD shows the pre-write value; the new value is visible after the edge.
- Width rules:
  - A bits above AW+1 take part only in the range check.
  - WD upper bits are ignored for sub-word stores.

Test Plan:
- Reset release with DEPTH=16: ready stays 0 for 16 cycles, rises on cycle 17; every word reads 0.
- Word store then halfword merge:
  - sw 0x11223344 @0x10, then sh 0xAAAA5566 @0x12.
  - Word read returns 0x55663344.
  - lh @0x12 returns 0x00005566; lb @0x13 with 0x55 returns 0x00000055.
- Sign extension: sb 0x80 @0x21; lb @0x21 returns 0xFFFFFF80; lbu returns 0x00000080.
- Misalignment:
  - sw @0x06 gives exc_align=1, con=0, no log, memory unchanged.
  - lh @0x03 gives exc_align=1, RD=0.
- Range: DEPTH=3072, sw @0x3000 gives exc_range=1 and no write; @0x2FFC writes successfully.
- Reset mid-sweep: pull reset low at sweep cycle 5; after release the sweep restarts and ready rises DEPTH cycles later; a WE asserted during CLEAR is dropped.
